in_service_priority_unit: RTL and testbench

- Priority resolver plus In-Service Register (ISR) for the 8259 PIC, downstream of the IRR latch and beside the control logic.
- Takes the pending IRR bits and the OCW1 mask, resolves fully-nested or rotating priority against in-service levels, and raises INT.
- On the two INTA acknowledge strobes, sets the ISR bit and returns the acknowledged IR number for the vector byte.
- Clears ISR bits on specific EOI, non-specific EOI or AEOI, and maintains the rotation pointer.

---
 rtl/in_service_priority_unit.sv | 90 +++++++++
 tb/tb_in_service_priority_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/in_service_priority_unit.sv
// in_service_priority_unit: 8259 priority resolver with in-service register, INTA sequencing and EOI handling
module in_service_priority_unit #(
    parameter int          NUM_IR      = 8,
    parameter logic [2:0]  SPURIOUS_ID = 3'd7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_IR-1:0] irr,
    input  logic [NUM_IR-1:0] imr,
    input  logic              sfnm,
    input  logic              aeoi,
    input  logic              rotate_aeoi,
    input  logic              ack1,
    input  logic              ack2,
    input  logic              eoi_valid,
    input  logic [2:0]        eoi_cmd,
    input  logic [2:0]        eoi_level,
    output logic              int_req,
    output logic [NUM_IR-1:0] isr,
    output logic [NUM_IR-1:0] clear_irr,
    output logic [2:0]        ack_id,
    output logic              ack_id_valid,
    output logic [2:0]        highest_isr
);
    typedef enum logic {IDLE, WAIT_ACK2} state_t;
    localparam logic [NUM_IR-1:0] ONE = 1;
    state_t            state;
    logic [2:0]        lowest, best, best_rank, hi_rank, id, eoi_low;
    logic              spurious, has_req, beats, take1, take2, next_wait, eoi_ns, eoi_sp, eoi_rot, auto_ok;
    logic [NUM_IR-1:0] eligible, eoi_clr, auto_clr, set_bit;
    // scan from lowest to highest priority so the last hit is the winner
    always_comb begin
        eligible    = irr & ~imr;
        best        = '0;
        best_rank   = '0;
        has_req     = 1'b0;
        highest_isr = '0;
        hi_rank     = '0;
        id          = '0;
        for (int r = 7; r >= 0; r--) begin
            id = lowest + 3'd1 + 3'(r);
            if (eligible[id]) begin
                best      = id;
                best_rank = 3'(r);
                has_req   = 1'b1;
            end
            if (isr[id]) begin
                highest_isr = id;
                hi_rank     = 3'(r);
            end
        end
        beats = has_req && (isr == '0 || best_rank < hi_rank || (sfnm && best_rank == hi_rank));
    end
    // command decode and next-state terms shared by the register update
    always_comb begin
        take1     = state == IDLE && ack1;
        take2     = state == WAIT_ACK2 && ack2;
        next_wait = take1 || (state == WAIT_ACK2 && !ack2);
        eoi_ns    = eoi_valid && eoi_cmd[1:0] == 2'b01 && isr != '0;
        eoi_sp    = eoi_valid && eoi_cmd[1:0] == 2'b11;
        eoi_clr   = eoi_ns ? ONE << highest_isr : eoi_sp ? ONE << eoi_level : '0;
        eoi_rot   = eoi_valid && eoi_cmd[2] && (eoi_cmd[1] || (eoi_cmd[0] && isr != '0));
        eoi_low   = eoi_cmd[1] ? eoi_level : highest_isr;
        auto_ok   = take2 && aeoi && !spurious;
        auto_clr  = auto_ok ? ONE << ack_id : '0;
        set_bit   = take1 && has_req ? ONE << best : '0;
    end
    // acknowledge sequencing, ISR set/clear and rotation pointer; EOI rotation wins over AEOI rotation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            isr          <= '0;
            lowest       <= 3'd7;
            spurious     <= 1'b0;
            clear_irr    <= '0;
            ack_id       <= '0;
            ack_id_valid <= 1'b0;
            int_req      <= 1'b0;
        end else begin
            state        <= next_wait ? WAIT_ACK2 : IDLE;
            isr          <= (isr & ~eoi_clr & ~auto_clr) | set_bit;
            lowest       <= eoi_rot ? eoi_low : (auto_ok && rotate_aeoi) ? ack_id : lowest;
            clear_irr    <= set_bit;
            ack_id       <= take1 ? (has_req ? best : SPURIOUS_ID) : ack_id;
            spurious     <= take1 ? !has_req : spurious;
            ack_id_valid <= take2;
            int_req      <= beats && !next_wait;
        end
    end
endmodule

// File: tb/tb_in_service_priority_unit.sv
// tb_in_service_priority_unit: directed and randomized checks against a rank-based reference model
module tb_in_service_priority_unit;
    logic       clk = 0, rst_n = 0;
    logic [7:0] irr = 0, imr = 0;
    logic       sfnm = 0, aeoi = 0, rotate_aeoi = 0, ack1 = 0, ack2 = 0, eoi_valid = 0;
    logic [2:0] eoi_cmd = 0, eoi_level = 0;
    logic       int_req, ack_id_valid;
    logic [7:0] isr, clear_irr;
    logic [2:0] ack_id, highest_isr;
    int total = 0, bad = 0;

    logic [7:0] m_isr, m_clr;
    int         m_low, m_ackid;
    bit         m_wait, m_spur, m_int, m_valid;

    in_service_priority_unit dut (
        .clk(clk), .rst_n(rst_n), .irr(irr), .imr(imr), .sfnm(sfnm), .aeoi(aeoi),
        .rotate_aeoi(rotate_aeoi), .ack1(ack1), .ack2(ack2), .eoi_valid(eoi_valid),
        .eoi_cmd(eoi_cmd), .eoi_level(eoi_level), .int_req(int_req), .isr(isr),
        .clear_irr(clear_irr), .ack_id(ack_id), .ack_id_valid(ack_id_valid), .highest_isr(highest_isr)
    );

    always #5 clk = ~clk;

    function automatic int rank(int i, int low);
        return (i - low - 1 + 16) % 8;
    endfunction

    function automatic int pick(logic [7:0] v, int low);
        int b = -1;
        for (int i = 0; i < 8; i++)
            if (v[i] && (b < 0 || rank(i, low) < rank(b, low))) b = i;
        return b;
    endfunction

    task automatic model_reset();
        m_isr = 0; m_clr = 0; m_low = 7; m_ackid = 0;
        m_wait = 0; m_spur = 0; m_int = 0; m_valid = 0;
    endtask

    task automatic cycle();
        int e, h, nl;
        logic [7:0] ni;
        bit nw, rot;
        e = pick(irr & ~imr, m_low);
        h = pick(m_isr, m_low);
        ni = m_isr; nl = m_low; nw = m_wait; rot = 0;
        m_clr = 0; m_valid = 0;
        if (eoi_valid) begin
            case (eoi_cmd)
                3'b001: if (h >= 0) ni[h] = 0;
                3'b011: ni[eoi_level] = 0;
                3'b101: if (h >= 0) begin ni[h] = 0; nl = h; rot = 1; end
                3'b111: begin ni[eoi_level] = 0; nl = eoi_level; rot = 1; end
                3'b110: begin nl = eoi_level; rot = 1; end
                default: ;
            endcase
        end
        if (!m_wait && ack1) begin
            nw = 1;
            if (e >= 0) begin ni[e] = 1; m_clr[e] = 1; m_ackid = e; m_spur = 0; end
            else begin m_ackid = 7; m_spur = 1; end
        end else if (m_wait && ack2) begin
            nw = 0; m_valid = 1;
            if (aeoi && !m_spur) begin
                ni[m_ackid] = 0;
                if (rotate_aeoi && !rot) nl = m_ackid;
            end
        end
        m_int = e >= 0 && (h < 0 || rank(e, m_low) < rank(h, m_low) ||
                (sfnm && rank(e, m_low) == rank(h, m_low))) && !nw;
        @(posedge clk); #1;
        m_isr = ni; m_low = nl; m_wait = nw;
        ack1 = 0; ack2 = 0; eoi_valid = 0;
    endtask

    task automatic eoi(input logic [2:0] c, input logic [2:0] l);
        eoi_valid = 1; eoi_cmd = c; eoi_level = l; cycle();
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        total++; if ({int_req, isr, clear_irr, ack_id, ack_id_valid, highest_isr} !== 0) begin bad++;
            $display("FAIL reset: got int=%0b isr=%h clr=%h id=%0d v=%0b hi=%0d want all 0", int_req, isr, clear_irr, ack_id, ack_id_valid, highest_isr); end
        @(posedge clk); #1; rst_n = 1;
    endtask

    task automatic test_basic_ack();
        irr = 8'h24; cycle();
        total++; if (int_req !== 1) begin bad++; $display("FAIL basic_int: got %0b want 1", int_req); end
        ack1 = 1; cycle();
        total++; if (isr !== 8'h04 || clear_irr !== 8'h04) begin bad++; $display("FAIL basic_ack1: got isr=%h clr=%h want 04 04", isr, clear_irr); end
        total++; if (int_req !== 0) begin bad++; $display("FAIL basic_wait_int: got %0b want 0", int_req); end
        cycle();
        total++; if (clear_irr !== 0) begin bad++; $display("FAIL basic_clr_pulse: got %h want 00", clear_irr); end
        ack2 = 1; cycle();
        total++; if (ack_id_valid !== 1 || ack_id !== 2) begin bad++; $display("FAIL basic_ack2: got v=%0b id=%0d want 1 2", ack_id_valid, ack_id); end
        cycle();
        total++; if (ack_id_valid !== 0) begin bad++; $display("FAIL basic_valid_pulse: got %0b want 0", ack_id_valid); end
    endtask

    task automatic test_nesting();
        irr = 8'h01; cycle();
        total++; if (int_req !== 1) begin bad++; $display("FAIL nest_ir0: got %0b want 1", int_req); end
        irr = 8'h08; cycle();
        total++; if (int_req !== 0) begin bad++; $display("FAIL nest_ir3: got %0b want 0", int_req); end
        irr = 8'h04; sfnm = 1; cycle();
        total++; if (int_req !== 1) begin bad++; $display("FAIL nest_sfnm: got %0b want 1", int_req); end
        sfnm = 0; cycle();
        total++; if (int_req !== 0) begin bad++; $display("FAIL nest_fnm: got %0b want 0", int_req); end
    endtask

    task automatic test_eoi();
        irr = 8'h10; ack1 = 1; cycle(); ack2 = 1; cycle();
        total++; if (isr !== 8'h14 || highest_isr !== 2) begin bad++; $display("FAIL eoi_setup: got isr=%h hi=%0d want 14 2", isr, highest_isr); end
        eoi(3'b001, 0);
        total++; if (isr !== 8'h10) begin bad++; $display("FAIL eoi_nonspec: got %h want 10", isr); end
        eoi(3'b011, 4);
        total++; if (isr !== 8'h00 || highest_isr !== 0) begin bad++; $display("FAIL eoi_spec: got isr=%h hi=%0d want 00 0", isr, highest_isr); end
        eoi(3'b101, 0);
        total++; if (isr !== 8'h00) begin bad++; $display("FAIL eoi_empty: got %h want 00", isr); end
    endtask

    task automatic test_rotate();
        eoi(3'b111, 3);
        irr = 8'h11; ack1 = 1; cycle();
        total++; if (isr !== 8'h10 || clear_irr !== 8'h10) begin bad++; $display("FAIL rot_ack1: got isr=%h clr=%h want 10 10", isr, clear_irr); end
        ack2 = 1; cycle();
        total++; if (ack_id !== 4 || ack_id_valid !== 1) begin bad++; $display("FAIL rot_id: got id=%0d v=%0b want 4 1", ack_id, ack_id_valid); end
        eoi(3'b011, 4); eoi(3'b110, 7);
    endtask

    task automatic test_spurious();
        irr = 0; ack1 = 1; cycle();
        total++; if (isr !== 0 || clear_irr !== 0) begin bad++; $display("FAIL spur_ack1: got isr=%h clr=%h want 00 00", isr, clear_irr); end
        ack2 = 1; cycle();
        total++; if (ack_id !== 7 || ack_id_valid !== 1) begin bad++; $display("FAIL spur_id: got id=%0d v=%0b want 7 1", ack_id, ack_id_valid); end
    endtask

    task automatic test_aeoi();
        aeoi = 1; rotate_aeoi = 1; irr = 8'h02; ack1 = 1; cycle(); ack2 = 1; cycle();
        total++; if (isr !== 0 || ack_id !== 1) begin bad++; $display("FAIL aeoi_clear: got isr=%h id=%0d want 00 1", isr, ack_id); end
        irr = 8'h06; ack1 = 1; cycle();
        total++; if (clear_irr !== 8'h04) begin bad++; $display("FAIL aeoi_rotate: got clr=%h want 04", clear_irr); end
        ack2 = 1; cycle();
        aeoi = 0; rotate_aeoi = 0; eoi(3'b110, 7);
    endtask

    task automatic test_reset_mid();
        irr = 8'h01; ack1 = 1; cycle();
        rst_n = 0; #1; model_reset();
        total++; if (isr !== 0 || int_req !== 0 || clear_irr !== 0) begin bad++; $display("FAIL rst_mid: got isr=%h int=%0b clr=%h want 00 0 00", isr, int_req, clear_irr); end
        @(posedge clk); #1; rst_n = 1; irr = 0; ack2 = 1; cycle();
        total++; if (ack_id_valid !== 0 || ack_id !== 0) begin bad++; $display("FAIL rst_no_valid: got v=%0b id=%0d want 0 0", ack_id_valid, ack_id); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            irr = 8'($urandom); imr = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00;
            sfnm = 1'($urandom_range(5) == 0); aeoi = 1'($urandom_range(3) == 0); rotate_aeoi = 1'($urandom);
            ack1 = 1'($urandom_range(2) == 0); ack2 = 1'($urandom_range(2) == 0);
            eoi_valid = 1'($urandom_range(3) == 0); eoi_cmd = 3'($urandom); eoi_level = 3'($urandom);
            cycle();
            total++; if (isr !== m_isr || clear_irr !== m_clr) begin bad++; $display("FAIL rnd_isr[%0d]: got isr=%h clr=%h want %h %h", n, isr, clear_irr, m_isr, m_clr); end
            total++; if (int_req !== m_int || ack_id_valid !== m_valid) begin bad++; $display("FAIL rnd_int[%0d]: got int=%0b v=%0b want %0b %0b", n, int_req, ack_id_valid, m_int, m_valid); end
            total++; if (m_valid && ack_id !== 3'(m_ackid)) begin bad++; $display("FAIL rnd_id[%0d]: got %0d want %0d", n, ack_id, m_ackid); end
            total++; if (highest_isr !== 3'(pick(m_isr, m_low) < 0 ? 0 : pick(m_isr, m_low))) begin bad++;
                $display("FAIL rnd_hi[%0d]: got %0d want %0d", n, highest_isr, pick(m_isr, m_low)); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_ack();
        test_nesting();
        test_eoi();
        test_rotate();
        test_spurious();
        test_aeoi();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
